// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage data-memory access unit for the 5-stage MIPS pipeline.
// Converts mem_ren/mem_wen into a level req/ack transaction on a slow external
// memory and stalls the pipeline until the transaction completes.
// Optional feature: define MEM_TIMEOUT_EN to abort a BUSY transaction after
// TIMEOUT cycles without ack (bus_err pulses in DONE). Without it BUSY waits
// indefinitely and bus_err is tied low.
module mem_access_unit #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mem_valid,
    input  logic                  mem_ren,
    input  logic                  mem_wen,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  mem_stall,
    output logic                  bus_err,
    output logic                  ext_req,
    output logic                  ext_we,
    output logic [ADDR_WIDTH-1:0] ext_addr,
    output logic [DATA_WIDTH-1:0] ext_wdata,
    input  logic [DATA_WIDTH-1:0] ext_rdata,
    input  logic                  ext_ack
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]            state_q, state_d;
    logic                  ext_req_q, ext_req_d;
    logic                  ext_we_q, ext_we_d;
    logic [ADDR_WIDTH-1:0] ext_addr_q, ext_addr_d;
    logic [DATA_WIDTH-1:0] ext_wdata_q, ext_wdata_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  acc;

    // A store wins when both ren and wen are set (ext_we = mem_wen).
    assign acc = mem_valid & (mem_ren | mem_wen);

    // Byte-address low bits are dropped (word-aligned bus); TIMEOUT is only
    // consumed by the optional timeout counter.
    logic unused_ok;
    assign unused_ok = ^{addr[1:0], 8'(TIMEOUT)};

`ifdef MEM_TIMEOUT_EN
    localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);
    logic [7:0] cnt_q, cnt_d;
    logic [7:0] cnt_inc;
    logic       bus_err_q, bus_err_d;
    assign cnt_inc = cnt_q + 8'd1;
    assign bus_err = bus_err_q;
`else
    assign bus_err = 1'b0;
`endif

    // Next-state and registered-output logic for the IDLE/BUSY/DONE transaction FSM.
    always_comb begin
        state_d     = state_q;
        ext_req_d   = ext_req_q;
        ext_we_d    = ext_we_q;
        ext_addr_d  = ext_addr_q;
        ext_wdata_d = ext_wdata_q;
        rdata_d     = rdata_q;
`ifdef MEM_TIMEOUT_EN
        cnt_d       = cnt_q;
        bus_err_d   = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (acc) begin
                    state_d     = S_BUSY;
                    ext_req_d   = 1'b1;
                    ext_we_d    = mem_wen;
                    ext_addr_d  = {addr[ADDR_WIDTH-1:2], 2'b00};
                    ext_wdata_d = wdata;
`ifdef MEM_TIMEOUT_EN
                    cnt_d       = '0;
`endif
                end
            end
            S_BUSY: begin
                if (ext_ack) begin
                    if (!ext_we_q) rdata_d = ext_rdata;
                    ext_req_d = 1'b0;
                    state_d   = S_DONE;
                end
`ifdef MEM_TIMEOUT_EN
                // Abort once the count of ack-less BUSY cycles reaches TIMEOUT.
                else if (cnt_inc == TIMEOUT_C) begin
                    cnt_d     = cnt_inc;
                    ext_req_d = 1'b0;
                    rdata_d   = '0;
                    bus_err_d = 1'b1;
                    state_d   = S_DONE;
                end else begin
                    cnt_d = cnt_inc;
                end
`endif
            end
            // DONE always returns to IDLE; a waiting access is evaluated there.
            default: state_d = S_IDLE;
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            ext_req_q   <= 1'b0;
            ext_we_q    <= 1'b0;
            ext_addr_q  <= '0;
            ext_wdata_q <= '0;
            rdata_q     <= '0;
`ifdef MEM_TIMEOUT_EN
            cnt_q       <= '0;
            bus_err_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            ext_req_q   <= ext_req_d;
            ext_we_q    <= ext_we_d;
            ext_addr_q  <= ext_addr_d;
            ext_wdata_q <= ext_wdata_d;
            rdata_q     <= rdata_d;
`ifdef MEM_TIMEOUT_EN
            cnt_q       <= cnt_d;
            bus_err_q   <= bus_err_d;
`endif
        end
    end

    // Stall: IDLE stalls only on a new access; BUSY always; DONE releases.
    always_comb begin
        mem_stall = 1'b0;
        if (!rst) begin
            case (state_q)
                S_IDLE:  mem_stall = acc;
                S_BUSY:  mem_stall = 1'b1;
                default: mem_stall = 1'b0;
            endcase
        end
    end

    assign ext_req   = ext_req_q;
    assign ext_we    = ext_we_q;
    assign ext_addr  = ext_addr_q;
    assign ext_wdata = ext_wdata_q;
    assign rdata     = rdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed self-checking bench for mem_access_unit (TIMEOUT=8).
// The timeout section follows MEM_TIMEOUT_EN the same way the design does.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_valid, mem_ren, mem_wen;
    logic [31:0] addr, wdata, rdata, ext_addr, ext_wdata, ext_rdata;
    logic        mem_stall, bus_err, ext_req, ext_we, ext_ack;

    int n_chk  = 0;
    int n_fail = 0;
    int stall_cnt = 0;

    mem_access_unit #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(8)) dut (
        .clk(clk), .rst(rst), .mem_valid(mem_valid), .mem_ren(mem_ren),
        .mem_wen(mem_wen), .addr(addr), .wdata(wdata), .rdata(rdata),
        .mem_stall(mem_stall), .bus_err(bus_err), .ext_req(ext_req),
        .ext_we(ext_we), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
        .ext_rdata(ext_rdata), .ext_ack(ext_ack)
    );

    always #5 clk = ~clk;

    // Stall cycles counted mid-cycle, away from the active edge.
    always @(negedge clk) if (mem_stall === 1'b1) stall_cnt <= stall_cnt + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    // One access starting in IDLE; ack arrives in BUSY cycle n_busy.
    task automatic access(input string tag, input logic ren, input logic wen,
                          input logic [31:0] a, input logic [31:0] wd, input int n_busy,
                          input logic [31:0] rd, input logic [31:0] exp_rdata,
                          input logic keep_next);
        int s0;
        s0 = stall_cnt;
        mem_valid = 1'b1; mem_ren = ren; mem_wen = wen; addr = a; wdata = wd;
        #1;
        chk({tag, " idle stall"}, mem_stall, 1'b1);
        chk({tag, " idle req"}, ext_req, 1'b0);
        tick;
        // Later input changes must not affect the transaction.
        mem_ren = ~ren; addr = ~a; wdata = ~wd;
        for (int i = 1; i <= n_busy; i++) begin
            ext_ack   = (i == n_busy);
            ext_rdata = (i == n_busy) ? rd : (32'hBAD0_0000 | 32'(i));
            #1;
            chk({tag, " busy req"}, ext_req, 1'b1);
            chk({tag, " busy addr"}, ext_addr, {a[31:2], 2'b00});
            chk({tag, " busy we"}, ext_we, wen);
            chk({tag, " busy wdata"}, ext_wdata, wd);
            chk({tag, " busy stall"}, mem_stall, 1'b1);
            tick;
        end
        ext_ack = 1'b0;
        if (keep_next) begin
            mem_valid = 1'b1; mem_ren = 1'b1; mem_wen = 1'b0;
        end else begin
            mem_valid = 1'b0; mem_ren = 1'b0; mem_wen = 1'b0;
        end
        #1;
        chk({tag, " done stall"}, mem_stall, 1'b0);
        chk({tag, " done req"}, ext_req, 1'b0);
        chk({tag, " done rdata"}, rdata, exp_rdata);
        chk({tag, " done bus_err"}, bus_err, 1'b0);
        tick;
        chk({tag, " stall cycles"}, 64'(stall_cnt - s0), 64'(n_busy + 1));
        chk({tag, " idle after req"}, ext_req, 1'b0);
        chk({tag, " rdata hold"}, rdata, exp_rdata);
    endtask

    initial begin
        rst = 1'b1; mem_valid = 1'b1; mem_ren = 1'b1; mem_wen = 1'b0;
        addr = 32'h0; wdata = 32'h0; ext_rdata = 32'h0; ext_ack = 1'b0;
        #1;
        chk("reset stall forced 0", mem_stall, 1'b0);
        tick; tick;
        chk("reset req", ext_req, 1'b0);
        chk("reset we", ext_we, 1'b0);
        chk("reset addr", ext_addr, 32'h0);
        chk("reset wdata", ext_wdata, 32'h0);
        chk("reset rdata", rdata, 32'h0);
        chk("reset bus_err", bus_err, 1'b0);
        chk("reset stall", mem_stall, 1'b0);
        mem_valid = 1'b0; mem_ren = 1'b0;
        tick;
        rst = 1'b0;
        tick;

        // Non-memory instructions pass with no stall and no request.
        mem_valid = 1'b1; mem_ren = 1'b0; mem_wen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("nonmem stall", mem_stall, 1'b0);
            chk("nonmem req", ext_req, 1'b0);
            tick;
        end
        mem_valid = 1'b0; mem_ren = 1'b1;
        #1;
        chk("invalid lw stall", mem_stall, 1'b0);
        tick;
        chk("invalid lw req", ext_req, 1'b0);
        mem_ren = 1'b0;

        // lw, misaligned byte address, ack in first BUSY cycle.
        access("lw1", 1'b1, 1'b0, 32'h0000_0013, 32'h0, 1, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0);
        // sw, ack in the fourth BUSY cycle; rdata keeps the previous load.
        access("sw", 1'b0, 1'b1, 32'h0000_0040, 32'h1234_5678, 4, 32'hCAFE_F00D, 32'hDEAD_BEEF, 1'b0);
        // ren and wen together act as a store.
        access("rw", 1'b1, 1'b1, 32'h0000_0088, 32'hA5A5_5A5A, 2, 32'h7777_7777, 32'hDEAD_BEEF, 1'b0);
        // Back-to-back loads: the second is pending through DONE and starts in IDLE.
        access("b2b1", 1'b1, 1'b0, 32'h0000_0100, 32'h0, 1, 32'h1111_1111, 32'h1111_1111, 1'b1);
        access("b2b2", 1'b1, 1'b0, 32'h0000_0206, 32'h0, 1, 32'h2222_2222, 32'h2222_2222, 1'b0);

        // Reset during BUSY abandons the transaction.
        mem_valid = 1'b1; mem_ren = 1'b1; addr = 32'h0000_0300;
        tick;
        chk("rstbusy req up", ext_req, 1'b1);
        rst = 1'b1;
        #1;
        chk("rstbusy stall", mem_stall, 1'b0);
        tick;
        rst = 1'b0; mem_valid = 1'b0; mem_ren = 1'b0;
        ext_ack = 1'b1; ext_rdata = 32'h9999_9999;
        #1;
        chk("rstbusy req dropped", ext_req, 1'b0);
        chk("rstbusy stall after", mem_stall, 1'b0);
        tick; tick;
        chk("rstbusy late ack rdata", rdata, 32'h0);
        chk("rstbusy late ack req", ext_req, 1'b0);
        ext_ack = 1'b0;
        tick;

        // No ack ever arrives.
        mem_valid = 1'b1; mem_ren = 1'b1; mem_wen = 1'b0; addr = 32'h0000_0404;
        ext_rdata = 32'h5555_5555;
        tick;
        mem_valid = 1'b0; mem_ren = 1'b0;
`ifdef MEM_TIMEOUT_EN
        for (int i = 1; i <= 8; i++) begin
            #1;
            chk("to busy stall", mem_stall, 1'b1);
            tick;
        end
        #1;
        chk("to done bus_err", bus_err, 1'b1);
        chk("to done rdata", rdata, 32'h0);
        chk("to done req", ext_req, 1'b0);
        chk("to done stall", mem_stall, 1'b0);
        ext_ack = 1'b1;
        tick;
        chk("to bus_err pulse", bus_err, 1'b0);
        tick;
        chk("to late ack rdata", rdata, 32'h0);
        ext_ack = 1'b0;
`else
        for (int i = 0; i < 300; i++) tick;
        #1;
        chk("noto still stall", mem_stall, 1'b1);
        chk("noto still req", ext_req, 1'b1);
        chk("noto bus_err", bus_err, 1'b0);
        rst = 1'b1;
        tick;
        rst = 1'b0;
`endif
        tick;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
